// File: rtl/booth_mul_sched_if.sv
// Handshake bundle between two DSP requesters, a product consumer and the
// shared Booth multiplier sequencer.
interface booth_mul_sched_if #(
    parameter int N = 16
) ();
    logic             req0_valid;
    logic             req0_ready;
    logic [N-1:0]     req0_m;
    logic [N-1:0]     req0_q;
    logic             req1_valid;
    logic             req1_ready;
    logic [N-1:0]     req1_m;
    logic [N-1:0]     req1_q;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [2*N-1:0]   rsp_p;
    logic             busy;

    modport master (
        output req0_valid, req0_m, req0_q,
        output req1_valid, req1_m, req1_q,
        output rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_p, busy
    );

    modport slave (
        input  req0_valid, req0_m, req0_q,
        input  req1_valid, req1_m, req1_q,
        input  rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_p, busy
    );
endinterface

// File: rtl/booth_mul_sched.sv
// Round-robin scheduler plus radix-2 Booth sequencer, one step per clock.
// Optional early exit when remaining multiplier bits are uniform: BMUL_EARLY_TERM_EN.
module booth_mul_sched #(
    parameter int N = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    booth_mul_sched_if.slave        bus
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            rr_ptr_q, rr_ptr_d;
    logic [N:0]      a_q, a_d;
    logic [N:0]      m_q, m_d;
    logic [N-1:0]    q_q, q_d;
    logic            qn1_q, qn1_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            id_q, id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_id_q, rsp_id_d;
    logic [2*N-1:0]  rsp_p_q, rsp_p_d;

    logic            grant0_s, grant1_s;
    logic [N:0]      a_sum_s;
    logic [2*N+1:0]  step_s;
    logic [N:0]      nxt_a_s;
    logic [N-1:0]    nxt_q_s;
    logic            nxt_qn1_s;
    logic            last_s;
`ifdef BMUL_EARLY_TERM_EN
    logic [N-1:0]    mask_s;
    logic            early_s;
    logic [CW:0]     sh_s;
    logic signed [2*N:0] shifted_s;
`endif

    // Arbitration: ties go to rr_ptr, lone requester always wins, nothing outside IDLE.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (state_q == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0_s = ~rr_ptr_q;
                grant1_s = rr_ptr_q;
            end else begin
                grant0_s = bus.req0_valid;
                grant1_s = bus.req1_valid;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Booth step datapath; A is N+1 bits so negating -2^(N-1) cannot overflow.
    always_comb begin
        a_sum_s = a_q;
        case ({q_q[0], qn1_q})
            2'b10:   a_sum_s = a_q - m_q;
            2'b01:   a_sum_s = a_q + m_q;
            default: a_sum_s = a_q;
        endcase
        step_s    = {a_sum_s[N], a_sum_s, q_q};
        nxt_a_s   = step_s[2*N+1:N+1];
        nxt_q_s   = step_s[N:1];
        nxt_qn1_s = step_s[0];
        last_s    = (cnt_q == CW'(N-1));
`ifdef BMUL_EARLY_TERM_EN
        // Remaining steps are pure shifts when every unprocessed bit equals qn1.
        mask_s    = {N{1'b1}} >> cnt_q;
        early_s   = (((q_q ^ {N{qn1_q}}) & mask_s) == {N{1'b0}});
        sh_s      = (CW+1)'(N) - {1'b0, cnt_q};
        shifted_s = $signed({a_q, q_q}) >>> sh_s;
        if (early_s) begin
            nxt_a_s   = shifted_s[2*N:N];
            nxt_q_s   = shifted_s[N-1:0];
            nxt_qn1_s = 1'b0;
            last_s    = 1'b1;
        end else begin
            nxt_qn1_s = step_s[0];
        end
`endif
    end

    // Sequencer next-state and register updates.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        a_d         = a_q;
        m_d         = m_q;
        q_d         = q_q;
        qn1_d       = qn1_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_p_d     = rsp_p_q;
        case (state_q)
            IDLE: begin
                if (grant0_s || grant1_s) begin
                    state_d  = ITER;
                    m_d      = grant1_s ? {bus.req1_m[N-1], bus.req1_m}
                                        : {bus.req0_m[N-1], bus.req0_m};
                    q_d      = grant1_s ? bus.req1_q : bus.req0_q;
                    a_d      = {(N+1){1'b0}};
                    qn1_d    = 1'b0;
                    cnt_d    = {CW{1'b0}};
                    id_d     = grant1_s;
                    rr_ptr_d = ~grant1_s;
                end else begin
                    state_d = IDLE;
                end
            end
            ITER: begin
                a_d   = nxt_a_s;
                q_d   = nxt_q_s;
                qn1_d = nxt_qn1_s;
                if (last_s) begin
                    state_d     = DONE;
                    cnt_d       = {CW{1'b0}};
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_p_d     = {nxt_a_s[N-1:0], nxt_q_s};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            a_q         <= {(N+1){1'b0}};
            m_q         <= {(N+1){1'b0}};
            q_q         <= {N{1'b0}};
            qn1_q       <= 1'b0;
            cnt_q       <= {CW{1'b0}};
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_p_q     <= {(2*N){1'b0}};
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            a_q         <= a_d;
            m_q         <= m_d;
            q_q         <= q_d;
            qn1_q       <= qn1_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_p_q     <= rsp_p_d;
        end
    end

    assign bus.req0_ready = grant0_s;
    assign bus.req1_ready = grant1_s;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_p      = rsp_p_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_booth_mul_sched.sv
// Self-checking bench for booth_mul_sched: directed corner products, round-robin
// fairness, response back-pressure, mid-operation reset and random traffic.
module tb_booth_mul_sched;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   exp_rr = 0;

    always #5 clk = ~clk;

    booth_mul_sched_if #(.N(N)) bus ();
    booth_mul_sched #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic [2*N-1:0] ref_mul(input logic signed [N-1:0] a,
                                               input logic signed [N-1:0] b);
        logic signed [63:0] t;
        t = 64'(a) * 64'(b);
        return t[2*N-1:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction from `side`; `both` keeps the other side requesting in the accept cycle.
    task automatic run_one(input int side, input logic [N-1:0] m, input logic [N-1:0] q,
                           input int hold, input int both);
        int lat;
        logic [2*N-1:0] exp_p;
        logic [2*N-1:0] held_p;
        logic held_id;
        exp_p = ref_mul(m, q);
        bus.req0_valid = (side == 0) || (both != 0);
        bus.req1_valid = (side == 1) || (both != 0);
        bus.req0_m = (side == 0) ? m : N'($urandom);
        bus.req0_q = (side == 0) ? q : N'($urandom);
        bus.req1_m = (side == 1) ? m : N'($urandom);
        bus.req1_q = (side == 1) ? q : N'($urandom);
        #1;
        check("grant_ready", {62'd0, bus.req1_ready, bus.req0_ready}, (side == 1) ? 64'd2 : 64'd1);
        exp_rr = 1 - side;
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_m = N'($urandom);
        bus.req0_q = N'($urandom);
        bus.req1_m = N'($urandom);
        bus.req1_q = N'($urandom);
        check("busy_iter", {63'd0, bus.busy}, 64'd1);
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 3*N) begin
            tick();
            lat++;
        end
`ifndef BMUL_EARLY_TERM_EN
        check("latency", 64'(lat), 64'(N));
`else
        check("no_timeout", {63'd0, (lat < 3*N)}, 64'd1);
`endif
        check("rsp_p", {32'd0, bus.rsp_p}, {32'd0, exp_p});
        check("rsp_id", {63'd0, bus.rsp_id}, 64'(side));
        held_p  = bus.rsp_p;
        held_id = bus.rsp_id;
        for (int h = 0; h < hold; h++) begin
            bus.req0_valid = 1'b1;
            bus.req1_valid = 1'b1;
            #1;
            check("done_no_ready", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
            tick();
            check("hold_valid", {63'd0, bus.rsp_valid}, 64'd1);
            check("hold_p", {32'd0, bus.rsp_p}, {32'd0, held_p});
            check("hold_id", {63'd0, bus.rsp_id}, {63'd0, held_id});
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        tick();
        check("rsp_drop", {63'd0, bus.rsp_valid}, 64'd0);
        check("busy_idle", {63'd0, bus.busy}, 64'd0);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        logic [N-1:0] op_m [2];
        logic [N-1:0] op_q [2];
        logic [2*N-1:0] exp_p;
        int g;
        int lat;
        int seen;
        int side;
        int both;

        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_m = '0;
        bus.req0_q = '0;
        bus.req1_m = '0;
        bus.req1_q = '0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        check("rst_rsp_id", {63'd0, bus.rsp_id}, 64'd0);
        check("rst_rsp_p", {32'd0, bus.rsp_p}, 64'd0);
        check("rst_ready", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
        rst = 1'b0;
        tick();

        // Directed corner products.
        run_one(0, 16'd3, 16'hFFFB, 0, 0);
        run_one(1, 16'h8000, 16'h8000, 5, 0);
        run_one(0, 16'h8000, 16'h0001, 0, 0);
        run_one(1, 16'h0000, 16'h1234, 1, 0);
        run_one(0, 16'h7FFF, 16'h0000, 0, 0);
        run_one(1, 16'h7FFF, 16'h8000, 0, 0);
        run_one(exp_rr, 16'hFFFF, 16'hFFFF, 0, 1);

        // Both requesters streaming: grants must alternate, one accept every N+2 cycles.
        op_m[0] = N'($urandom); op_q[0] = N'($urandom);
        op_m[1] = N'($urandom); op_q[1] = N'($urandom);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.rsp_ready  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.req0_m = op_m[0]; bus.req0_q = op_q[0];
            bus.req1_m = op_m[1]; bus.req1_q = op_q[1];
            #1;
            check("rr_one_grant", 64'(int'(bus.req0_ready) + int'(bus.req1_ready)), 64'd1);
            g = (bus.req1_ready === 1'b1) ? 1 : 0;
            check("rr_side", 64'(g), 64'(exp_rr));
            exp_p  = ref_mul(op_m[g], op_q[g]);
            exp_rr = 1 - g;
            tick();
            op_m[g] = N'($urandom);
            op_q[g] = N'($urandom);
            bus.req0_m = op_m[0]; bus.req0_q = op_q[0];
            bus.req1_m = op_m[1]; bus.req1_q = op_q[1];
            lat = 0;
            while (bus.rsp_valid !== 1'b1 && lat < 3*N) begin
                tick();
                lat++;
            end
`ifndef BMUL_EARLY_TERM_EN
            check("rr_latency", 64'(lat), 64'(N));
`endif
            check("rr_p", {32'd0, bus.rsp_p}, {32'd0, exp_p});
            check("rr_id", {63'd0, bus.rsp_id}, 64'(g));
            check("rr_done_ready", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b0;
        #1;

        // Reset in the middle of an iteration aborts it and re-prefers requester 0.
        bus.req0_valid = 1'b1;
        bus.req0_m = 16'd1234;
        bus.req0_q = 16'd567;
        #1;
        check("abort_accept", {63'd0, bus.req0_ready}, 64'd1);
        tick();
        bus.req0_valid = 1'b0;
        repeat (7) tick();
        check("abort_busy_pre", {63'd0, bus.busy}, 64'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        tick();
        rst = 1'b0;
        exp_rr = 0;
        bus.rsp_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < N + 4; c++) begin
            tick();
            if (bus.rsp_valid === 1'b1) seen++;
        end
        check("abort_no_rsp", 64'(seen), 64'd0);
        bus.rsp_ready = 1'b0;
        run_one(0, 16'd100, 16'hFF9C, 0, 1);

        // Random traffic against the arithmetic model.
        for (int i = 0; i < 10; i++) begin
            both = int'($urandom_range(0, 1));
            side = (both != 0) ? exp_rr : int'($urandom_range(0, 1));
            run_one(side, N'($urandom), N'($urandom), int'($urandom_range(0, 2)), both);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
